spi_slave_responder: RTL and testbench
======================================

# spi_slave_responder

SPI mode-0 slave that sits directly downstream of the SPI master IO block, on the far side of the `spiClk`/`mosi`/`miso`/`cs` wires. It oversamples the SPI lines in the system clock domain, deserialises MOSI bytes into a small receive FIFO, and serialises response bytes from a single-entry transmit holding register onto MISO. It serves as the bench-side target for the master and as the template for on-chip SPI peripherals.

## Interface
- `DATA_WIDTH`, 8: bits per SPI byte, shifted MSB first.
- `RX_DEPTH`, 4: receive FIFO entries; must be a power of 2, at least 2.
- `FILL_BYTE`, 8'hFF: byte shifted out when no transmit byte is held.
- `sysClk` in 1: system clock. Single clock domain; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `spiClk` in 1: SPI clock from the master. It is asynchronous and idles low.
- `mosi` in 1: serial data from the master.
- `cs` in 1: chip select, active low.
- `miso` out 1: serial data to the master.
- `rx_data` out DATA_WIDTH: head of the receive FIFO (show-ahead).
- `rx_valid` out 1: receive FIFO not empty.
- `rx_pop` in 1: active-high; pops the head entry when `rx_valid`=1.
- `tx_data` in DATA_WIDTH: next response byte.
- `tx_load` in 1: active-high; writes `tx_data` into the holding register when `tx_ready`=1.
- `tx_ready` out 1: holding register empty.
- `busy` out 1: frame in progress (state ACTIVE).
- `byte_count` out 8: complete bytes received in the current or most recent frame. Saturates at 255.
- `overrun` out 1: sticky; a received byte was dropped because the FIFO was full.
- `underrun` out 1: sticky; `FILL_BYTE` was sent because the holding register was empty.
- `frame_error` out 1: sticky; `cs` rose with a partial byte.
- `clr_status` in 1: active-high; clears all three sticky flags.

## Operation
- **Input synchronisers.** `spiClk`, `mosi` and `cs` each pass through a 2-flop synchroniser. A further register on synced `spiClk` and synced `cs` provides edge detection (`sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`).
- **State machine.** Two states, IDLE and ACTIVE.
  - IDLE → ACTIVE on `cs_fall`.
  - ACTIVE → IDLE on `cs_rise`.
  - SPI edges seen in IDLE are ignored.
- **On `cs_fall`:**
  - `tx_shift` is loaded with the holding register if it is valid; the holding register then empties. Otherwise `tx_shift` is loaded with `FILL_BYTE` and `underrun` is set.
  - `bit_cnt` and `byte_count` clear to 0; `reload_pending` clears.
- **On `sclk_rise` in ACTIVE:**
  - `rx_shift` shifts left with synced `mosi` entering the LSB; `bit_cnt` increments.
  - At `bit_cnt`=DATA_WIDTH-1 the byte is complete: push `{rx_shift[DATA_WIDTH-2:0], mosi_s}` into the FIFO, clear `bit_cnt` to 0, increment `byte_count` (saturating), and set `reload_pending`.
  - If the FIFO is full and `rx_pop` is not asserted in the same cycle, the byte is dropped and `overrun` is set.
- **On `sclk_fall` in ACTIVE:**
  - If `reload_pending`: reload `tx_shift` using the same rule as `cs_fall` (holding register, else `FILL_BYTE` with `underrun` set), then clear `reload_pending`.
  - Otherwise `tx_shift` shifts left by 1.
- **MISO.** `miso` = `tx_shift[DATA_WIDTH-1]` in ACTIVE and 1 in IDLE.
- **On `cs_rise` with `bit_cnt`≠0:** the partial byte is discarded with no push, and `frame_error` is set. `bit_cnt` clears to 0.
- **Receive FIFO.**
  - Pop when empty is ignored.
  - Simultaneous push and pop when full: both occur, the count is unchanged, and there is no overrun.
  - Pointers wrap modulo `RX_DEPTH`.
- **Transmit holding register.** `tx_load` while `tx_ready`=0 is ignored, and the held byte is unchanged. A load in the same cycle as a consume is accepted for the next byte, because the consume happens first.
- **Sticky flags.** `clr_status` and a set in the same cycle: the set wins.

## Timing
- **Reset values:**
  - `miso`=1, `busy`=0, `rx_valid`=0, `rx_data`=0.
  - `tx_ready`=1, `byte_count`=0.
  - `overrun`=`underrun`=`frame_error`=0.
  - State IDLE; FIFO empty.
  - `reset` mid-frame aborts with no flags set, and the block stays IDLE until the next `cs_fall`.
- **Edge latency.** An SPI pin edge is acted on 3 `sysClk` edges later: 2 synchroniser stages plus the detect register.
- **Pin-to-`miso` latency.** `miso` updates 1 cycle after the action edge, i.e. 4 cycles after the pin edge.
- **Clock constraint.** The `spiClk` half-period must be at least 6 `sysClk` cycles; the master's divider gives exactly 6. The first `spiClk` rise must arrive at least 6 cycles after `cs` falls.
- **`rx_valid` latency.** `rx_valid` rises the cycle after the push.
- **Pop latency.** `rx_pop` updates `rx_data` and `rx_valid` on the next cycle.
- **`tx_ready` latency.** `tx_ready` falls the cycle after an accepted `tx_load`, and rises the cycle after a consume.

## Test plan
- **Single byte, loopback value.** Preload `tx_data`=8'hA5; master sends 8'h3C. Required: the master receives 8'hA5; `rx_data`=8'h3C with `rx_valid`=1; `byte_count`=1; `tx_ready`=1; no flags set.
- **Four-byte frame.** MOSI 01,02,03,04 with TX reloaded to 10,11,12,13 as `tx_ready` rises. Required: the FIFO pops 01..04 in order; the master receives 10..13; `byte_count`=4.
- **Overrun.** With `RX_DEPTH`=4, no pops, send 5 bytes. Required: the FIFO holds bytes 1..4, byte 5 is dropped, and `overrun`=1. Then `clr_status` → `overrun`=0.
- **Underrun.** Frame starts with no preload. Required: the master receives 8'hFF and `underrun`=1.
- **Partial byte.** `cs` rises after 5 bits. Required: no push; `frame_error`=1; `busy`=0.
- **Edge cases.**
  - Push and pop in the same cycle with the FIFO full: count stays 4 and `overrun`=0.
  - `reset` asserted mid-byte: all outputs return to their reset values, and the next frame receives correctly.

Source files
------------

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversamples spiClk/mosi/cs in the sysClk domain, deserialises
// MOSI into a small show-ahead receive FIFO and serialises a held response byte onto MISO.
//
// state  | meaning
// IDLE   | cs high, SPI edges ignored, miso driven high
// ACTIVE | frame in progress, shifting on spiClk edges

module spi_slave_responder #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    RX_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] FILL_BYTE  = 8'hFF
) (
  input  logic                  sysClk,
  input  logic                  reset,
  input  logic                  spiClk,
  input  logic                  mosi,
  input  logic                  cs,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_pop,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic                  busy,
  output logic [7:0]            byte_count,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  frame_error,
  input  logic                  clr_status
);

  localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronisers and edge-detect registers are deliberately left unreset so a
  // cs held low through reset does not look like a fresh cs_fall afterwards.
  logic sclk_s1_q, sclk_s2_q, sclk_dly_q;
  logic mosi_s1_q, mosi_s2_q;
  logic cs_s1_q, cs_s2_q, cs_dly_q;

  always_ff @(posedge sysClk) begin
    sclk_s1_q  <= spiClk;
    sclk_s2_q  <= sclk_s1_q;
    sclk_dly_q <= sclk_s2_q;
    mosi_s1_q  <= mosi;
    mosi_s2_q  <= mosi_s1_q;
    cs_s1_q    <= cs;
    cs_s2_q    <= cs_s1_q;
    cs_dly_q   <= cs_s2_q;
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_rise = sclk_s2_q & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s2_q & sclk_dly_q;
  assign cs_fall   = ~cs_s2_q & cs_dly_q;
  assign cs_rise   = cs_s2_q & ~cs_dly_q;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-2:0]   rx_shift_q, rx_shift_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]              byte_count_q, byte_count_d;
  logic                    reload_pending_q, reload_pending_d;
  logic                    miso_q, miso_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic                    overrun_q, overrun_d;
  logic                    underrun_q, underrun_d;
  logic                    frame_error_q, frame_error_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0]   mem_q [RX_DEPTH];

  logic [DATA_WIDTH-1:0]   rx_byte;
  logic                    consume;
  logic                    push_req;
  logic                    push_eff;
  logic                    pop_eff;
  logic                    fifo_full;
  logic                    set_overrun;
  logic                    set_underrun;
  logic                    set_frame_error;

  assign rx_byte = {rx_shift_q, mosi_s2_q};

  always_comb begin
    state_d          = state_q;
    tx_shift_d       = tx_shift_q;
    rx_shift_d       = rx_shift_q;
    bit_cnt_d        = bit_cnt_q;
    byte_count_d     = byte_count_q;
    reload_pending_d = reload_pending_q;
    consume          = 1'b0;
    push_req         = 1'b0;
    set_underrun     = 1'b0;
    set_frame_error  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d          = ACTIVE;
          consume          = 1'b1;
          bit_cnt_d        = '0;
          byte_count_d     = '0;
          reload_pending_d = 1'b0;
        end
      end
      ACTIVE: begin
        // cs_rise wins over a coincident sclk_fall so a master that drops the
        // clock and deselects together does not trigger a spurious reload.
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (bit_cnt_q != '0) set_frame_error = 1'b1;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = rx_byte[DATA_WIDTH-2:0];
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d        = '0;
              push_req         = 1'b1;
              reload_pending_d = 1'b1;
              if (byte_count_q != 8'hFF) byte_count_d = byte_count_q + 8'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
          if (sclk_fall) begin
            if (reload_pending_q) begin
              consume          = 1'b1;
              reload_pending_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume) begin
      if (hold_valid_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d   = FILL_BYTE;
        set_underrun = 1'b1;
      end
    end

    miso_d = (state_q == ACTIVE) ? tx_shift_q[DATA_WIDTH-1] : 1'b1;
  end

  // Holding register: a consume frees the slot before a same-cycle load lands.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (consume) hold_valid_d = 1'b0;
    if (tx_load && (!hold_valid_q || consume)) begin
      hold_valid_d = 1'b1;
      hold_d       = tx_data;
    end
  end

  always_comb begin
    fifo_full   = (count_q == FULL_CNT);
    pop_eff     = rx_pop && (count_q != '0);
    push_eff    = push_req && (!fifo_full || pop_eff);
    set_overrun = push_req && fifo_full && !pop_eff;
    wr_ptr_d    = push_eff ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop_eff ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);

    overrun_d     = (overrun_q & ~clr_status) | set_overrun;
    underrun_d    = (underrun_q & ~clr_status) | set_underrun;
    frame_error_d = (frame_error_q & ~clr_status) | set_frame_error;
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q          <= IDLE;
      tx_shift_q       <= '0;
      rx_shift_q       <= '0;
      bit_cnt_q        <= '0;
      byte_count_q     <= '0;
      reload_pending_q <= 1'b0;
      miso_q           <= 1'b1;
      hold_q           <= '0;
      hold_valid_q     <= 1'b0;
      overrun_q        <= 1'b0;
      underrun_q       <= 1'b0;
      frame_error_q    <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q          <= state_d;
      tx_shift_q       <= tx_shift_d;
      rx_shift_q       <= rx_shift_d;
      bit_cnt_q        <= bit_cnt_d;
      byte_count_q     <= byte_count_d;
      reload_pending_q <= reload_pending_d;
      miso_q           <= miso_d;
      hold_q           <= hold_d;
      hold_valid_q     <= hold_valid_d;
      overrun_q        <= overrun_d;
      underrun_q       <= underrun_d;
      frame_error_q    <= frame_error_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      if (push_eff) mem_q[wr_ptr_q] <= rx_byte;
    end
  end

  assign miso        = miso_q;
  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_valid    = (count_q != '0);
  assign tx_ready    = ~hold_valid_q;
  assign busy        = (state_q == ACTIVE);
  assign byte_count  = byte_count_q;
  assign overrun     = overrun_q;
  assign underrun    = underrun_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: drives a mode-0 master with a
// 6-cycle spiClk half-period and checks hand-computed results.

module tb_spi_slave_responder;

  logic       sysClk = 1'b0;
  logic       reset;
  logic       spiClk;
  logic       mosi;
  logic       cs;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       busy;
  logic [7:0] byte_count;
  logic       overrun;
  logic       underrun;
  logic       frame_error;
  logic       clr_status;

  int vectors     = 0;
  int miscompares = 0;

  spi_slave_responder #(
    .DATA_WIDTH(8),
    .RX_DEPTH  (4),
    .FILL_BYTE (8'hFF)
  ) dut (
    .sysClk     (sysClk),
    .reset      (reset),
    .spiClk     (spiClk),
    .mosi       (mosi),
    .cs         (cs),
    .miso       (miso),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_pop     (rx_pop),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .byte_count (byte_count),
    .overrun    (overrun),
    .underrun   (underrun),
    .frame_error(frame_error),
    .clr_status (clr_status)
  );

  always #5 sysClk = ~sysClk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_tx(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic pop();
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0;
  endtask

  task automatic clear_flags();
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
  endtask

  task automatic wait_tx_ready(input string tag);
    for (int n = 0; n < 20; n++) begin
      if (tx_ready) break;
      tick(1);
    end
    check(tag, 32'(tx_ready), 32'd1);
  endtask

  // Shifts bits 7 down to 8-nbits; when last, cs rises together with the final spiClk fall.
  task automatic xfer(input logic [7:0] b, input int nbits, input bit last, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      tick(6);
      spiClk = 1'b1;
      got[i] = miso;
      tick(6);
      spiClk = 1'b0;
      if (last && i == 8 - nbits) cs = 1'b1;
    end
  endtask

  logic [7:0] g;
  logic [7:0] got_b [4];

  initial begin
    reset = 1'b1; spiClk = 1'b0; mosi = 1'b0; cs = 1'b1;
    rx_pop = 1'b0; tx_data = 8'h00; tx_load = 1'b0; clr_status = 1'b0;
    tick(6);
    reset = 1'b0;
    tick(2);

    // reset state
    check("rst_miso", 32'(miso), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    check("rst_flags", 32'({overrun, underrun, frame_error}), 32'd0);

    // single byte: A5 out, 3C in; second load while full is ignored
    load_tx(8'hA5);
    check("t1_tx_ready_low", 32'(tx_ready), 32'd0);
    load_tx(8'h5B);
    cs = 1'b0;
    tick(6);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_miso_msb", 32'(miso), 32'd1);
    xfer(8'h3C, 8, 1'b1, g);
    tick(8);
    check("t1_master_rx", 32'(g), 32'hA5);
    check("t1_rx_data", 32'(rx_data), 32'h3C);
    check("t1_rx_valid", 32'(rx_valid), 32'd1);
    check("t1_byte_count", 32'(byte_count), 32'd1);
    check("t1_tx_ready", 32'(tx_ready), 32'd1);
    check("t1_flags", 32'({overrun, underrun, frame_error}), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    pop();
    check("t1_empty_after_pop", 32'(rx_valid), 32'd0);
    pop();
    check("t1_pop_empty_ignored", 32'(rx_valid), 32'd0);

    // four-byte frame with reloads
    load_tx(8'h10);
    cs = 1'b0;
    tick(6);
    check("t2_miso_msb", 32'(miso), 32'd0);
    wait_tx_ready("t2_ready0");
    load_tx(8'h11);
    xfer(8'h01, 8, 1'b0, got_b[0]);
    wait_tx_ready("t2_ready1");
    load_tx(8'h12);
    xfer(8'h02, 8, 1'b0, got_b[1]);
    wait_tx_ready("t2_ready2");
    load_tx(8'h13);
    xfer(8'h03, 8, 1'b0, got_b[2]);
    xfer(8'h04, 8, 1'b1, got_b[3]);
    tick(8);
    check("t2_master_rx0", 32'(got_b[0]), 32'h10);
    check("t2_master_rx1", 32'(got_b[1]), 32'h11);
    check("t2_master_rx2", 32'(got_b[2]), 32'h12);
    check("t2_master_rx3", 32'(got_b[3]), 32'h13);
    check("t2_byte_count", 32'(byte_count), 32'd4);
    check("t2_flags", 32'({overrun, underrun, frame_error}), 32'd0);
    check("t2_pop0", 32'(rx_data), 32'h01); pop();
    check("t2_pop1", 32'(rx_data), 32'h02); pop();
    check("t2_pop2", 32'(rx_data), 32'h03); pop();
    check("t2_pop3", 32'(rx_data), 32'h04); pop();
    check("t2_empty", 32'(rx_valid), 32'd0);

    // overrun: five bytes, no pops
    cs = 1'b0;
    tick(6);
    xfer(8'hA1, 8, 1'b0, g);
    xfer(8'hA2, 8, 1'b0, g);
    xfer(8'hA3, 8, 1'b0, g);
    xfer(8'hA4, 8, 1'b0, g);
    xfer(8'hA5, 8, 1'b1, g);
    tick(8);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_byte_count", 32'(byte_count), 32'd5);
    check("t3_pop0", 32'(rx_data), 32'hA1); pop();
    check("t3_pop1", 32'(rx_data), 32'hA2); pop();
    check("t3_pop2", 32'(rx_data), 32'hA3); pop();
    check("t3_pop3", 32'(rx_data), 32'hA4); pop();
    check("t3_fifo_drained", 32'(rx_valid), 32'd0);
    clear_flags();
    check("t3_clr", 32'({overrun, underrun, frame_error}), 32'd0);

    // underrun: no preload
    cs = 1'b0;
    tick(6);
    xfer(8'h55, 8, 1'b1, g);
    tick(8);
    check("t4_master_rx", 32'(g), 32'hFF);
    check("t4_underrun", 32'(underrun), 32'd1);
    check("t4_rx_data", 32'(rx_data), 32'h55);
    pop();
    clear_flags();

    // partial byte: cs rises after 5 bits
    cs = 1'b0;
    tick(6);
    xfer(8'hC7, 5, 1'b1, g);
    tick(8);
    check("t5_frame_error", 32'(frame_error), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_no_push", 32'(rx_valid), 32'd0);
    check("t5_byte_count", 32'(byte_count), 32'd0);
    clear_flags();

    // push and pop in the same cycle with the FIFO full
    cs = 1'b0;
    tick(6);
    xfer(8'hB1, 8, 1'b0, g);
    xfer(8'hB2, 8, 1'b0, g);
    xfer(8'hB3, 8, 1'b0, g);
    xfer(8'hB4, 8, 1'b0, g);
    xfer(8'hB5, 7, 1'b0, g);
    mosi = 1'b1;
    tick(6);
    spiClk = 1'b1;
    tick(2);
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0;
    tick(3);
    spiClk = 1'b0;
    cs = 1'b1;
    tick(8);
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_byte_count", 32'(byte_count), 32'd5);
    check("t6_pop0", 32'(rx_data), 32'hB2); pop();
    check("t6_pop1", 32'(rx_data), 32'hB3); pop();
    check("t6_pop2", 32'(rx_data), 32'hB4); pop();
    check("t6_valid_last", 32'(rx_valid), 32'd1);
    check("t6_pop3", 32'(rx_data), 32'hB5); pop();
    check("t6_empty", 32'(rx_valid), 32'd0);
    clear_flags();

    // reset mid-byte with data in the FIFO and a held byte
    load_tx(8'h77);
    cs = 1'b0;
    tick(6);
    xfer(8'h12, 8, 1'b0, g);
    load_tx(8'h88);
    xfer(8'h34, 3, 1'b0, g);
    check("t7_pre_valid", 32'(rx_valid), 32'd1);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("t7_miso", 32'(miso), 32'd1);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_rx_valid", 32'(rx_valid), 32'd0);
    check("t7_rx_data", 32'(rx_data), 32'h00);
    check("t7_tx_ready", 32'(tx_ready), 32'd1);
    check("t7_byte_count", 32'(byte_count), 32'd0);
    check("t7_flags", 32'({overrun, underrun, frame_error}), 32'd0);
    tick(10);
    check("t7_stays_idle", 32'(busy), 32'd0);
    cs = 1'b1;
    tick(8);
    check("t7_idle_after_cs", 32'({busy, overrun, underrun, frame_error}), 32'd0);
    load_tx(8'h5A);
    cs = 1'b0;
    tick(6);
    xfer(8'hC3, 8, 1'b1, g);
    tick(8);
    check("t7_master_rx", 32'(g), 32'h5A);
    check("t7_rx_data_new", 32'(rx_data), 32'hC3);
    check("t7_byte_count_new", 32'(byte_count), 32'd1);
    check("t7_flags_new", 32'({overrun, underrun, frame_error}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
